// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter of fetch and data ports onto a single-outstanding memory bus
module mem_bus_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_address,
    output logic        o_if_busy,
    output logic [31:0] o_if_data,
    output logic        o_if_DV,
    input  logic        i_d_req,
    input  logic [31:0] i_d_address,
    input  logic [31:0] i_d_data,
    input  logic [2:0]  i_d_bhw,
    input  logic        i_d_write,
    output logic        o_d_busy,
    output logic [31:0] o_d_data,
    output logic        o_d_DV,
    output logic        o_d_err,
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t      state;
    logic        gnt, last;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_bhw;
    logic        d_write;
    logic        d_ok, if_cap, d_cap, d_rej, if_eff, d_eff, pick_d;
    logic [31:0] if_addr_eff, d_addr_eff, d_wdata_eff;
    logic [2:0]  d_bhw_eff;
    logic        d_write_eff;

    assign d_ok   = (i_d_bhw == 3'b100) | (i_d_bhw == 3'b010) | (i_d_bhw == 3'b001);
    assign if_cap = i_if_req & ~o_if_busy;
    assign d_cap  = i_d_req & ~o_d_busy & d_ok;
    assign d_rej  = i_d_req & ~o_d_busy & ~d_ok;
    // In IDLE a busy port is pending-not-issued, so a request arriving this edge can be granted at once
    assign if_eff = o_if_busy | if_cap;
    assign d_eff  = o_d_busy | d_cap;
    assign pick_d = d_eff & (~if_eff | ~last);
    assign if_addr_eff = o_if_busy ? if_addr : i_if_address;
    assign d_addr_eff  = o_d_busy ? d_addr : i_d_address;
    assign d_wdata_eff = o_d_busy ? d_wdata : i_d_data;
    assign d_bhw_eff   = o_d_busy ? d_bhw : i_d_bhw;
    assign d_write_eff = o_d_busy ? d_write : i_d_write;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            gnt             <= 1'b0;
            last            <= ~DATA_PRIORITY;
            if_addr         <= '0;
            d_addr          <= '0;
            d_wdata         <= '0;
            d_bhw           <= '0;
            d_write         <= 1'b0;
            o_if_busy       <= 1'b0;
            o_if_data       <= '0;
            o_if_DV         <= 1'b0;
            o_d_busy        <= 1'b0;
            o_d_data        <= '0;
            o_d_DV          <= 1'b0;
            o_d_err         <= 1'b0;
            o_bus_data      <= '0;
            o_bus_address   <= '0;
            o_bus_DV        <= 1'b0;
            o_bhw           <= '0;
            o_write_notread <= 1'b0;
        end else begin
            o_if_DV  <= 1'b0;
            o_d_DV   <= 1'b0;
            o_d_err  <= 1'b0;
            o_bus_DV <= 1'b0;
            if (if_cap) begin
                o_if_busy <= 1'b1;
                if_addr   <= i_if_address;
            end
            if (d_cap) begin
                o_d_busy <= 1'b1;
                d_addr   <= i_d_address;
                d_wdata  <= i_d_data;
                d_bhw    <= i_d_bhw;
                d_write  <= i_d_write;
            end
            if (d_rej) begin
                o_d_DV   <= 1'b1;
                o_d_err  <= 1'b1;
                o_d_data <= '0;
            end
            case (state)
                IDLE: if (if_eff | d_eff) begin
                    gnt             <= pick_d;
                    o_bus_DV        <= 1'b1;
                    o_bus_address   <= pick_d ? d_addr_eff : if_addr_eff;
                    o_bhw           <= pick_d ? d_bhw_eff : 3'b100;
                    o_write_notread <= pick_d & d_write_eff;
                    o_bus_data      <= pick_d ? d_wdata_eff : 32'h0;
                    state           <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (i_bus_DV) begin
                    last  <= gnt;
                    state <= IDLE;
                    if (gnt) begin
                        o_d_DV   <= 1'b1;
                        o_d_data <= d_write ? 32'h0 : i_bus_data;
                        o_d_busy <= 1'b0;
                    end else begin
                        o_if_DV   <= 1'b1;
                        o_if_data <= i_bus_data;
                        o_if_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
